// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, flush-to-bubble
// and a saturating back-pressure counter. Optional zero-latency path: PIPE_STAGE_SKID_BYPASS_EN.
module pipe_stage_skid #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  BUBBLE     = {DATA_WIDTH{1'b0}},
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   main_q, main_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_WIDTH-1:0]    stall_q, stall_d;
  logic                    bypass_s;
  logic                    in_fire_s;
  logic                    out_fire_s;

  assign in_ready = (state_q != FULL) && !flush;

`ifdef PIPE_STAGE_SKID_BYPASS_EN
  // An empty stage with both neighbours ready hands the payload straight through.
  assign bypass_s  = (state_q == EMPTY) && !flush && in_valid && out_ready;
  assign out_valid = ((state_q != EMPTY) || bypass_s) && !flush;
  assign out_data  = bypass_s ? in_data : main_q;
`else
  assign bypass_s  = 1'b0;
  assign out_valid = (state_q != EMPTY) && !flush;
  assign out_data  = main_q;
`endif

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;
  assign stall_cnt  = stall_q;

  // Occupancy decode from the state encoding.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state, storage and stall counter update.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end

    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          // A bypassed transfer leaves the stage empty.
          if (in_fire_s && !bypass_s) begin
            state_d = ONE;
            main_d  = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data;
          end else if (in_fire_s) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire_s) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      stall_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed table-driven bench for pipe_stage_skid: streaming, back-pressure,
// flush, counter saturation and first-word latency.
module tb_pipe_stage_skid;

  localparam logic [31:0] BUB = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(
    .DATA_WIDTH (32),
    .BUBBLE     (BUB),
    .CNT_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
    logic [3:0]  e_st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_ir, input logic e_ov,
                         input logic [31:0] e_od, input logic [1:0] e_occ, input logic [3:0] e_st);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    chk({tag, ".out_data"},  out_data, e_od);
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, e_occ});
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e_st});
  endtask

  initial begin
    // Streaming 1..8 with out_ready high: one cycle latency, then one word per cycle.
    tbl.push_back('{1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0, BUB,   2'd0, 4'd0});
    for (int i = 2; i <= 8; i++) begin
      tbl.push_back('{1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 1'b1, 32'(i - 1), 2'd1, 4'd0});
    end
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd8, 2'd1, 4'd0});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, BUB,   2'd0, 4'd0});
    // Back-pressure: A, B accepted, C held upstream; drain in order.
    tbl.push_back('{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, BUB,   2'd0, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 4'd1});
    tbl.push_back('{1'b0, 1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h11, 2'd2, 4'd2});
    tbl.push_back('{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1, 4'd2});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 32'h33, 2'd1, 4'd2});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'h33, 2'd1, 4'd3});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, BUB,   2'd0, 4'd3});
    // Flush while FULL: no transfer, stage empties to bubble, counter unchanged.
    tbl.push_back('{1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, BUB,   2'd0, 4'd3});
    tbl.push_back('{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h44, 2'd1, 4'd3});
    tbl.push_back('{1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 32'h44, 2'd2, 4'd4});
    tbl.push_back('{1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 1'b0, BUB,   2'd0, 4'd4});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'h77, 2'd1, 4'd4});
    tbl.push_back('{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, BUB,   2'd0, 4'd4});

    // Reset held two cycles while upstream offers data.
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    tick();
    tick();
    chk_all("reset", 1'b1, 1'b0, BUB, 2'd0, 4'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od,
              tbl[i].e_occ, tbl[i].e_st);
      tick();
    end

    // Reset coincident with flush: reset wins and clears the counter.
    flush    = 1'b1;
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    rst   = 1'b1;
    #1;
    chk_all("rst_flush", 1'b1, 1'b0, BUB, 2'd0, 4'd0);

    // Saturation: one held word, out_ready low for 20 cycles.
    in_valid  = 1'b1;
    in_data   = 32'h99;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("sat%0d.stall_cnt", i), {28'd0, stall_cnt}, (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("sat%0d.out_data", i), out_data, 32'h99);
      tick();
    end
    chk("sat_final.stall_cnt", {28'd0, stall_cnt}, 32'd15);

    // First-word latency from an empty stage with both sides ready.
    rst = 1'b0;
    tick();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hCAFE;
    out_ready = 1'b1;
    #1;
`ifdef PIPE_STAGE_SKID_BYPASS_EN
    chk_all("lat0", 1'b1, 1'b1, 32'hCAFE, 2'd0, 4'd0);
`else
    chk_all("lat0", 1'b1, 1'b0, BUB, 2'd0, 4'd0);
`endif
    tick();
    in_valid = 1'b0;
    #1;
`ifdef PIPE_STAGE_SKID_BYPASS_EN
    chk_all("lat1", 1'b1, 1'b0, BUB, 2'd0, 4'd0);
`else
    chk_all("lat1", 1'b1, 1'b1, 32'hCAFE, 2'd1, 4'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
